// File: rtl/smem_access_ctrl_pkg.sv
// Shared types and constants for the S-RAM access controller.
package smem_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } smem_state_e;

  // Client slots; lower index means higher priority
  localparam int CLIENT_INIT    = 0;
  localparam int CLIENT_SHUFFLE = 1;
  localparam int CLIENT_DECRYPT = 2;

  // S RAM geometry
  localparam int SMEM_DEPTH  = 256;
  localparam int SMEM_ADDR_W = 8;
  localparam int SMEM_DATA_W = 8;

  // Width of the grant index and of the read-latency down-counter (latency 1..3)
  localparam int GRANT_W   = 2;
  localparam int LAT_CNT_W = 2;

endpackage

// File: rtl/smem_access_ctrl_if.sv
// Client handshake bus plus S RAM port of the access controller.
interface smem_access_ctrl_if #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
);
  // Client side
  logic [NUM_CLIENTS-1:0]        req;
  logic [NUM_CLIENTS-1:0]        wr;
  logic [NUM_CLIENTS*ADDR_W-1:0] addr;
  logic [NUM_CLIENTS*DATA_W-1:0] wdata;
  logic [NUM_CLIENTS-1:0]        done;
  logic [DATA_W-1:0]             rdata;
  logic [1:0]                    grant_idx;
  logic                          busy;
  // RAM side
  logic [ADDR_W-1:0]             ram_address;
  logic [DATA_W-1:0]             ram_data;
  logic                          ram_wren;
  logic [DATA_W-1:0]             ram_q;

  // Controller view
  modport slave (
    input  req, wr, addr, wdata, ram_q,
    output done, rdata, grant_idx, busy, ram_address, ram_data, ram_wren
  );

  // Client-side initiator view
  modport master (
    output req, wr, addr, wdata,
    input  done, rdata, grant_idx, busy
  );

  // RAM view
  modport ram (
    input  ram_address, ram_data, ram_wren,
    output ram_q
  );
endinterface

// File: rtl/smem_access_ctrl_prio_arbiter.sv
// Combinational fixed-priority select: the lowest-indexed requester wins.
module smem_prio_arbiter
  import smem_pkg::*;
#(
  parameter int NUM_CLIENTS = 3
) (
  input  logic [NUM_CLIENTS-1:0] i_req,
  output logic [NUM_CLIENTS-1:0] o_grant_oh,
  output logic [GRANT_W-1:0]     o_grant_idx,
  output logic                   o_any
);

  // Scan from the lowest priority upward so the lowest index overwrites last
  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant_oh     = '0;
        o_grant_oh[i]  = 1'b1;
        o_grant_idx    = GRANT_W'(i);
        o_any          = 1'b1;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/smem_access_ctrl.sv
// Responder for the RC4 loop FSMs: arbitrates clients and serialises
// single-byte accesses onto one single-port, registered-read S RAM.
module smem_access_ctrl
  import smem_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  smem_access_ctrl_if.slave bus
);

  smem_state_e              r_state;
  smem_state_e              w_next;

  logic [NUM_CLIENTS-1:0]   w_grant_oh;
  logic [GRANT_W-1:0]       w_grant_idx;
  logic                     w_any;

  logic [NUM_CLIENTS-1:0]   r_grant_oh;
  logic [GRANT_W-1:0]       r_grant_idx;
  logic                     r_wr;
  logic [LAT_CNT_W-1:0]     r_cnt;

  logic [NUM_CLIENTS-1:0]   r_done;
  logic [DATA_W-1:0]        r_rdata;
  logic                     r_busy;
  logic [ADDR_W-1:0]        r_ram_address;
  logic [DATA_W-1:0]        r_ram_data;
  logic                     r_ram_wren;

  logic [ADDR_W-1:0]        w_sel_addr;
  logic [DATA_W-1:0]        w_sel_wdata;
  logic                     w_sel_wr;

  smem_prio_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_arb (
    .i_req       (bus.req),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Fields of the granted client, only trusted once SETTLE has elapsed
  assign w_sel_addr  = bus.addr[r_grant_idx*ADDR_W +: ADDR_W];
  assign w_sel_wdata = bus.wdata[r_grant_idx*DATA_W +: DATA_W];
  assign w_sel_wr    = bus.wr[r_grant_idx];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; reads pass through WAIT for the RAM latency
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = ST_SETTLE;
        else       w_next = ST_IDLE;
      end
      ST_SETTLE: w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (r_wr) w_next = ST_DONE;
        else      w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == LAT_CNT_W'(1)) w_next = ST_DONE;
        else                        w_next = ST_WAIT;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Grant is latched in IDLE and held until the transaction returns to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_oh  <= '0;
      r_grant_idx <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_grant_oh  <= w_grant_oh;
      r_grant_idx <= w_grant_idx;
    end
  end

  // Capture the granted request at the end of SETTLE; it also drives the RAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr          <= 1'b0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
    end else if (r_state == ST_SETTLE) begin
      r_wr          <= w_sel_wr;
      r_ram_address <= w_sel_addr;
      r_ram_data    <= w_sel_wdata;
    end
  end

  // Write enable is high only for the single ACCESS cycle of a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_wren <= 1'b0;
    end else begin
      r_ram_wren <= (r_state == ST_SETTLE) ? w_sel_wr : 1'b0;
    end
  end

  // Read latency counter and read-data capture on the last WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rdata <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_cnt <= LAT_CNT_W'(RAM_LATENCY);
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt - LAT_CNT_W'(1);
      if (r_cnt == LAT_CNT_W'(1)) r_rdata <= bus.ram_q;
    end
  end

  // Done pulse and busy flag, registered from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= '0;
      r_busy <= 1'b0;
    end else begin
      r_done <= (w_next == ST_DONE) ? r_grant_oh : '0;
      r_busy <= (w_next != ST_IDLE);
    end
  end

  assign bus.done        = r_done;
  assign bus.rdata       = r_rdata;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.busy        = r_busy;
  assign bus.ram_address = r_ram_address;
  assign bus.ram_data    = r_ram_data;
  assign bus.ram_wren    = r_ram_wren;

endmodule

// File: tb/tb_smem_access_ctrl.sv
// Directed bench for smem_access_ctrl: table of single transactions plus
// hand-written contention, held-request, reset and latency-2 sequences.
module tb_smem_access_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  smem_access_ctrl_if #(.NUM_CLIENTS(3), .ADDR_W(8), .DATA_W(8)) b1 ();
  smem_access_ctrl_if #(.NUM_CLIENTS(3), .ADDR_W(8), .DATA_W(8)) b2 ();

  smem_access_ctrl #(.NUM_CLIENTS(3), .ADDR_W(8), .DATA_W(8), .RAM_LATENCY(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (b1)
  );
  smem_access_ctrl #(.NUM_CLIENTS(3), .ADDR_W(8), .DATA_W(8), .RAM_LATENCY(2)) dut2 (
    .clk (clk), .rst_n (rst_n), .bus (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM initial contents
  function automatic logic [7:0] ram_init(input logic [7:0] a);
    case (a)
      8'h01:   return 8'hC1;
      8'h02:   return 8'hC2;
      8'h03:   return 8'h33;
      8'h04:   return 8'h44;
      8'h05:   return 8'hA3;
      8'hFE:   return 8'h3C;
      8'hFF:   return 8'hE7;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic [7:0] q2_s1;

  // Latency-1 S RAM model for dut1
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem1[i] <= ram_init(8'(i));
    end else if (b1.ram_wren) begin
      mem1[b1.ram_address] <= b1.ram_data;
    end
    b1.ram_q <= mem1[b1.ram_address];
  end

  // Latency-2 S RAM model for dut2
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem2[i] <= ram_init(8'(i));
    end else if (b2.ram_wren) begin
      mem2[b2.ram_address] <= b2.ram_data;
    end
    q2_s1    <= mem2[b2.ram_address];
    b2.ram_q <= q2_s1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         client;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [6];

  // One transaction on dut1; addr/wdata become valid only one cycle after req
  task automatic run_txn(input string tag, input int c, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input int exp_cyc, input logic [7:0] exp_rd);
    int         done_cyc, pulses, wren_cnt, wren_cyc;
    logic [7:0] wa, wd, rd;
    logic [2:0] done_val;
    done_cyc = -1; pulses = 0; wren_cnt = 0; wren_cyc = -1;
    wa = 8'h00; wd = 8'h00; rd = 8'h00; done_val = 3'b000;
    b1.req = 3'b000;
    b1.req[c] = 1'b1;
    b1.wr[c]  = w;
    b1.addr[c*8 +: 8]  = ~a;
    b1.wdata[c*8 +: 8] = ~d;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      if (cyc > 0) tick();
      if (b1.done != 3'b000) begin
        pulses++;
        done_val = b1.done;
        rd = b1.rdata;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (b1.ram_wren) begin
        wren_cnt++;
        wren_cyc = cyc;
        wa = b1.ram_address;
        wd = b1.ram_data;
      end
      if (cyc == 1) begin
        b1.addr[c*8 +: 8]  = a;
        b1.wdata[c*8 +: 8] = d;
      end
      if (b1.done[c]) b1.req[c] = 1'b0;
    end
    b1.req = 3'b000;
    check({tag, ".done_cycle"}, done_cyc, exp_cyc);
    check({tag, ".done_pulses"}, pulses, 1);
    check({tag, ".done_bits"}, int'(done_val), 1 << c);
    check({tag, ".wren_cycles"}, wren_cnt, int'(w));
    check({tag, ".grant_idx"}, int'(b1.grant_idx), c);
    if (w) begin
      check({tag, ".wren_cycle"}, wren_cyc, 2);
      check({tag, ".ram_address"}, int'(wa), int'(a));
      check({tag, ".ram_data"}, int'(wd), int'(d));
    end else begin
      check({tag, ".rdata"}, int'(rd), int'(exp_rd));
    end
  endtask

  initial begin
    int         d0_cyc, d2_cyc, multi, step, busy5, busy9, late_done;
    int         swap_cyc [3];
    logic [7:0] rd0, rd2, swap_rd;
    logic       swap_wr [3];
    logic [7:0] swap_a [3];
    logic [7:0] swap_d [3];

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    b1.req = 3'b000; b1.wr = 3'b000; b1.addr = 24'h0; b1.wdata = 24'h0;
    b2.req = 3'b000; b2.wr = 3'b000; b2.addr = 24'h0; b2.wdata = 24'h0;

    vecs[0] = '{client: 1, wr: 1'b0, addr: 8'h05, wdata: 8'h00, exp_rd: 8'hA3, exp_cyc: 4};
    vecs[1] = '{client: 0, wr: 1'b1, addr: 8'h10, wdata: 8'h5C, exp_rd: 8'h00, exp_cyc: 3};
    vecs[2] = '{client: 0, wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rd: 8'h5C, exp_cyc: 4};
    vecs[3] = '{client: 2, wr: 1'b0, addr: 8'hFE, wdata: 8'h00, exp_rd: 8'h3C, exp_cyc: 4};
    vecs[4] = '{client: 1, wr: 1'b1, addr: 8'hFF, wdata: 8'h00, exp_rd: 8'h00, exp_cyc: 3};
    vecs[5] = '{client: 1, wr: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rd: 8'h00, exp_cyc: 4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.done", int'(b1.done), 0);
    check("rst.ram_wren", int'(b1.ram_wren), 0);
    check("rst.busy", int'(b1.busy), 0);
    check("rst.ram_address", int'(b1.ram_address), 0);
    check("rst.ram_data", int'(b1.ram_data), 0);
    check("rst.rdata", int'(b1.rdata), 0);
    check("rst.grant_idx", int'(b1.grant_idx), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle.busy", int'(b1.busy), 0);

    // Table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].client, vecs[v].wr, vecs[v].addr,
              vecs[v].wdata, vecs[v].exp_cyc, vecs[v].exp_rd);
      tick();
    end

    // Contention: clients 0 and 2 read in the same cycle
    d0_cyc = -1; d2_cyc = -1; multi = 0; rd0 = 8'h00; rd2 = 8'h00;
    b1.wr = 3'b000;
    b1.addr = {8'h02, 8'h00, 8'h01};
    b1.req = 3'b101;
    for (int cyc = 0; cyc <= 16; cyc++) begin
      if (cyc > 0) tick();
      if ($countones(b1.done) > 1) multi++;
      if (b1.done == 3'b001) begin d0_cyc = cyc; rd0 = b1.rdata; b1.req[0] = 1'b0; end
      if (b1.done == 3'b100) begin d2_cyc = cyc; rd2 = b1.rdata; b1.req[2] = 1'b0; end
    end
    b1.req = 3'b000;
    check("cont.done0_cycle", d0_cyc, 4);
    check("cont.rdata0", int'(rd0), 8'hC1);
    check("cont.done2_cycle", d2_cyc, 9);
    check("cont.rdata2", int'(rd2), 8'hC2);
    check("cont.multi_done", multi, 0);
    tick();

    // Swap: client 2 holds req through read 0x03, write 0x03<-0x77, write 0x04<-0x11
    swap_wr = '{1'b0, 1'b1, 1'b1};
    swap_a  = '{8'h03, 8'h03, 8'h04};
    swap_d  = '{8'h00, 8'h77, 8'h11};
    swap_cyc = '{-1, -1, -1};
    step = 0; busy5 = -1; busy9 = -1; swap_rd = 8'h00;
    b1.wr[2] = swap_wr[0]; b1.addr[16 +: 8] = swap_a[0]; b1.wdata[16 +: 8] = swap_d[0];
    b1.req[2] = 1'b1;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (cyc > 0) tick();
      if (cyc == 5) busy5 = int'(b1.busy);
      if (cyc == 9) busy9 = int'(b1.busy);
      if (b1.done[2] && step < 3) begin
        swap_cyc[step] = cyc;
        if (step == 0) swap_rd = b1.rdata;
        step++;
        if (step < 3) begin
          b1.wr[2] = swap_wr[step]; b1.addr[16 +: 8] = swap_a[step]; b1.wdata[16 +: 8] = swap_d[step];
        end else begin
          b1.req[2] = 1'b0;
        end
      end
    end
    b1.req = 3'b000;
    check("swap.pulses", step, 3);
    check("swap.done_cycle0", swap_cyc[0], 4);
    check("swap.done_cycle1", swap_cyc[1], 8);
    check("swap.done_cycle2", swap_cyc[2], 12);
    check("swap.read_data", int'(swap_rd), 8'h33);
    check("swap.idle_busy5", busy5, 0);
    check("swap.idle_busy9", busy9, 0);
    check("swap.ram03", int'(mem1[8'h03]), 8'h77);
    check("swap.ram04", int'(mem1[8'h04]), 8'h11);
    tick();

    // RAM_LATENCY=2 build: read of 0xFF
    d0_cyc = -1; rd0 = 8'h00;
    b2.wr = 3'b000; b2.addr = {16'h0000, 8'hFF}; b2.req = 3'b001;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      if (cyc > 0) tick();
      if (b2.done[0] && d0_cyc < 0) begin d0_cyc = cyc; rd0 = b2.rdata; b2.req[0] = 1'b0; end
    end
    b2.req = 3'b000;
    check("lat2.done_cycle", d0_cyc, 5);
    check("lat2.rdata", int'(rd0), 8'hE7);

    // Reset asserted while a read is in WAIT
    b1.wr[1] = 1'b0; b1.addr[8 +: 8] = 8'h05; b1.req = 3'b010;
    tick(); tick(); tick();
    check("rstwait.busy_before", int'(b1.busy), 1);
    rst_n = 1'b0;
    #1;
    check("rstwait.done", int'(b1.done), 0);
    check("rstwait.ram_wren", int'(b1.ram_wren), 0);
    check("rstwait.busy", int'(b1.busy), 0);
    check("rstwait.rdata", int'(b1.rdata), 0);
    tick(); tick();
    b1.req = 3'b000;
    rst_n = 1'b1;
    late_done = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (b1.done != 3'b000) late_done++;
    end
    check("rstwait.no_late_done", late_done, 0);
    run_txn("post_rst", 1, 1'b0, 8'h05, 8'h00, 4, 8'hA3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/smem_access_ctrl.md
Name: smem_access_ctrl

Overview:
- Responder end of the request/write/request_finished memory handshake used by the RC4 loop FSMs (S-init, key-shuffle, decrypt loops).
- Arbitrates between NUM_CLIENTS initiators and serialises their single-byte reads and writes onto one single-port S RAM (256x8, registered read).
- Returns read data on a shared bus and a one-cycle done pulse to the granted client.

Parameters:
- NUM_CLIENTS, 3, number of initiator FSMs; index 0 has highest priority.
- ADDR_W, 8, S RAM address width.
- DATA_W, 8, S RAM data width.
- RAM_LATENCY, 1, cycles from RAM address registration to valid ram_q; legal range 1..3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_CLIENTS  per-client request level; high while the client is in an access state.
- wr  in  NUM_CLIENTS  per-client write flag; 1 = write, 0 = read.
- addr  in  NUM_CLIENTS*ADDR_W  per-client address; client n uses bits [n*ADDR_W +: ADDR_W].
- wdata  in  NUM_CLIENTS*DATA_W  per-client write data, packed the same way.
- done  out  NUM_CLIENTS  one-cycle completion pulse (request_finished) to the granted client.
- rdata  out  DATA_W  read data; valid while done is high; otherwise holds its last value.
- grant_idx  out  2  index of the current or last granted client (debug).
- busy  out  1  high in every state except IDLE.
- ram_address  out  ADDR_W  S RAM address.
- ram_data  out  DATA_W  S RAM write data.
- ram_wren  out  1  S RAM write enable.
- ram_q  in  DATA_W  S RAM read data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; done=0, ram_wren=0, busy=0, ram_address=0, ram_data=0, rdata=0, grant_idx=0. Any in-flight access is abandoned; no done pulse follows.
- State sequence: IDLE -> SETTLE -> ACCESS -> (WAIT x RAM_LATENCY, reads only) -> DONE -> IDLE.
- IDLE:
  - If any req bit is high, grant the lowest-indexed requester, latch grant_idx, go to SETTLE.
  - If no req bit is high, stay in IDLE.
- SETTLE: one dead cycle. Clients register addr and wdata on the first edge of their access state, so those inputs are not trusted until this cycle.
- End of SETTLE: capture addr, wr and wdata of the granted client into internal registers, then go to ACCESS. req/wr/addr changes after this capture are ignored.
- ACCESS:
  - ram_address = captured addr and ram_data = captured wdata.
  - ram_wren = captured wr, asserted for exactly this one cycle.
  - Next state: writes go to DONE; reads go to WAIT.
- WAIT:
  - A down-counter is loaded with RAM_LATENCY and decremented each WAIT cycle.
  - On the last WAIT cycle, ram_q is registered into rdata, then the FSM goes to DONE.
- DONE: done[grant_idx]=1 for one cycle; all other done bits stay 0. Next state is IDLE.
- Latency, counting cycle 0 as the cycle where req is first high in IDLE:
  - Write: done high in cycle 3.
  - Read: done high in cycle 3+RAM_LATENCY (cycle 4 at the default).
- Held request:
  - A client that keeps req high across done (e.g. a read_j -> write swap sequence) is treated as issuing a new transaction.
  - After the mandatory IDLE cycle it is re-arbitrated and goes through SETTLE again.
  - Each done pulse therefore corresponds to exactly one RAM access.
- Simultaneous requests: fixed priority, lowest index wins. The grant is locked until DONE; higher-priority requests arriving mid-transaction wait for IDLE. No fairness is required.
- req dropping mid-transaction: the transaction still completes and done is still pulsed. Clients must not drop req.
- ram_address and ram_data hold their values outside ACCESS. ram_wren is 0 in every state except ACCESS.
- Address arithmetic: none. Addresses pass through unmodified; 8-bit values wrap naturally within the 256-entry RAM.
- Unused or illegal state encodings recover to IDLE.

Decomposition:
- Package smem_pkg:
  - State enum (IDLE, SETTLE, ACCESS, WAIT, DONE).
  - Client index constants: CLIENT_INIT=0, CLIENT_SHUFFLE=1, CLIENT_DECRYPT=2.
  - S RAM depth/width constants.
- One sub-module: smem_prio_arbiter. Combinational fixed-priority select that takes req and produces a one-hot grant plus encoded index. The main FSM registers its output in IDLE.

Test Plan:
- Single read: RAM[0x05]=0xA3; client 1 raises req with wr=0, addr=0x05 -> done[1] high in cycle 4 only, rdata=0xA3, ram_wren never high.
- Single write: client 0 with wr=1, addr=0x10, wdata=0x5C -> ram_wren high for exactly one cycle (cycle 2) with ram_address=0x10, ram_data=0x5C; done[0] in cycle 3. A following read of 0x10 returns 0x5C.
- Contention: clients 0 and 2 both request in the same cycle (reads of 0x01 and 0x02) -> client 0 is served first with done[0]; then client 2 with done[2] and rdata=RAM[0x02]; never two done bits high at once.
- Swap sequence: client 2 holds req high through a read of 0x03 followed by writes 0x03<-0x77 and 0x04<-0x11 -> three separate done pulses, each preceded by IDLE and SETTLE; final RAM[0x03]=0x77, RAM[0x04]=0x11.
- Reset mid-read: assert rst_n=0 during WAIT -> done stays 0, ram_wren=0, busy=0 immediately. After release a new request completes normally.
- RAM_LATENCY=2 build: read of 0xFF -> done in cycle 5 and rdata equals the ram_q value sampled two cycles after ACCESS.
